// File: rtl/ocx_tlx_xmt_credit_mgr_if.sv
// Transmit credit manager bus: TLX credit returns/consumes in, TL credit
// return request out. slave = credit manager view, master = driving side.
interface ocx_tlx_xmt_credit_mgr_if #(
  parameter int VC_W  = 8,
  parameter int DCP_W = 10
);
  logic             dlx_tlx_link_up;
  logic             rcv_xmt_tlx_credit_valid;
  logic [3:0]       rcv_xmt_tlx_credit_vc0;
  logic [3:0]       rcv_xmt_tlx_credit_vc3;
  logic [5:0]       rcv_xmt_tlx_credit_dcp0;
  logic [5:0]       rcv_xmt_tlx_credit_dcp3;
  logic             rcv_xmt_tl_credit_vc0_valid;
  logic             rcv_xmt_tl_credit_vc1_valid;
  logic             rcv_xmt_tl_credit_dcp0_valid;
  logic             rcv_xmt_tl_credit_dcp1_valid;
  logic             rcv_xmt_tl_crd_cfg_dcp1_valid;
  logic             xmt_vc0_consume;
  logic             xmt_vc3_consume;
  logic [2:0]       xmt_dcp0_consume;
  logic [2:0]       xmt_dcp3_consume;
  logic [VC_W-1:0]  tlx_vc0_credits;
  logic [VC_W-1:0]  tlx_vc3_credits;
  logic [DCP_W-1:0] tlx_dcp0_credits;
  logic [DCP_W-1:0] tlx_dcp3_credits;
  logic             crd_ret_valid;
  logic [3:0]       crd_ret_vc0;
  logic [3:0]       crd_ret_vc1;
  logic [5:0]       crd_ret_dcp0;
  logic [5:0]       crd_ret_dcp1;
  logic             crd_ret_taken;
  logic             crd_overflow_err;
  logic             crd_underflow_err;

  modport slave (
    input  dlx_tlx_link_up, rcv_xmt_tlx_credit_valid,
           rcv_xmt_tlx_credit_vc0, rcv_xmt_tlx_credit_vc3,
           rcv_xmt_tlx_credit_dcp0, rcv_xmt_tlx_credit_dcp3,
           rcv_xmt_tl_credit_vc0_valid, rcv_xmt_tl_credit_vc1_valid,
           rcv_xmt_tl_credit_dcp0_valid, rcv_xmt_tl_credit_dcp1_valid,
           rcv_xmt_tl_crd_cfg_dcp1_valid,
           xmt_vc0_consume, xmt_vc3_consume, xmt_dcp0_consume, xmt_dcp3_consume,
           crd_ret_taken,
    output tlx_vc0_credits, tlx_vc3_credits, tlx_dcp0_credits, tlx_dcp3_credits,
           crd_ret_valid, crd_ret_vc0, crd_ret_vc1, crd_ret_dcp0, crd_ret_dcp1,
           crd_overflow_err, crd_underflow_err
  );

  modport master (
    output dlx_tlx_link_up, rcv_xmt_tlx_credit_valid,
           rcv_xmt_tlx_credit_vc0, rcv_xmt_tlx_credit_vc3,
           rcv_xmt_tlx_credit_dcp0, rcv_xmt_tlx_credit_dcp3,
           rcv_xmt_tl_credit_vc0_valid, rcv_xmt_tl_credit_vc1_valid,
           rcv_xmt_tl_credit_dcp0_valid, rcv_xmt_tl_credit_dcp1_valid,
           rcv_xmt_tl_crd_cfg_dcp1_valid,
           xmt_vc0_consume, xmt_vc3_consume, xmt_dcp0_consume, xmt_dcp3_consume,
           crd_ret_taken,
    input  tlx_vc0_credits, tlx_vc3_credits, tlx_dcp0_credits, tlx_dcp3_credits,
           crd_ret_valid, crd_ret_vc0, crd_ret_vc1, crd_ret_dcp0, crd_ret_dcp1,
           crd_overflow_err, crd_underflow_err
  );
endinterface

// File: rtl/ocx_tlx_xmt_credit_mgr.sv
// TLX transmit credit manager: tracks TLX credits available to the transmitter
// and batches freed TL credits into return_tl_credits requests.

// Saturating credit counter: next = cnt + add - sub, clamped to [0, all-ones].
// o_ovf/o_unf flag the clamp this cycle so the parent can latch sticky errors.
module ocx_tlx_xmt_crd_cnt #(
  parameter int W     = 8,
  parameter int ADD_W = 4,
  parameter int SUB_W = 1
) (
  input  logic             tlx_clk,
  input  logic             reset_n,
  input  logic             i_clr,
  input  logic [ADD_W-1:0] i_add,
  input  logic [SUB_W-1:0] i_sub,
  output logic [W-1:0]     o_cnt,
  output logic             o_ovf,
  output logic             o_unf
);
  localparam int XW = W + ADD_W + SUB_W + 1;
  localparam logic [XW-1:0] MAX = {{(XW-W){1'b0}}, {W{1'b1}}};

  logic [W-1:0]  r_cnt;
  logic [XW-1:0] w_sum, w_sub, w_net;

  assign w_sum = XW'(r_cnt) + XW'(i_add);
  assign w_sub = XW'(i_sub);
  assign w_net = w_sum - w_sub;
  assign o_unf = (w_sub > w_sum);
  assign o_ovf = !o_unf && (w_net > MAX);
  assign o_cnt = r_cnt;

  // Counter register: clear while link is down, otherwise clamp the net update
  always_ff @(posedge tlx_clk or negedge reset_n) begin
    if (!reset_n)   r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (o_unf) r_cnt <= '0;
    else if (o_ovf) r_cnt <= '1;
    else            r_cnt <= w_net[W-1:0];
  end
endmodule

module ocx_tlx_xmt_credit_mgr #(
  parameter int VC_W  = 8,
  parameter int DCP_W = 10
) (
  input logic                     tlx_clk,
  input logic                     reset_n,
  ocx_tlx_xmt_credit_mgr_if.slave bus
);
  typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

  state_t r_state;
  logic   r_ret_valid, r_ovf_err, r_unf_err;
  logic [1:0][3:0] r_ret_vc;
  logic [1:0][5:0] r_ret_dcp;

  logic w_clr, w_any, w_start;
  logic [7:0] w_ovf, w_unf;

  // lane 0 = vc0/dcp0, lane 1 = vc3/dcp3 for TLX; vc0/vc1, dcp0/dcp1 for TL pending
  logic [1:0][3:0]       w_vc_ret;
  logic [1:0]            w_vc_cons;
  logic [1:0][VC_W-1:0]  w_vc_cnt;
  logic [1:0][5:0]       w_dcp_ret;
  logic [1:0][2:0]       w_dcp_cons;
  logic [1:0][DCP_W-1:0] w_dcp_cnt;
  logic [1:0]            w_pvc_inc;
  logic [1:0][3:0]       w_pvc_sub, w_snap_vc;
  logic [1:0][6:0]       w_pvc_cnt;
  logic [1:0][1:0]       w_pdcp_inc;
  logic [1:0][5:0]       w_pdcp_sub, w_snap_dcp;
  logic [1:0][7:0]       w_pdcp_cnt;

  assign w_clr = !bus.dlx_tlx_link_up;

  assign w_vc_ret[0]   = bus.rcv_xmt_tlx_credit_valid ? bus.rcv_xmt_tlx_credit_vc0  : 4'd0;
  assign w_vc_ret[1]   = bus.rcv_xmt_tlx_credit_valid ? bus.rcv_xmt_tlx_credit_vc3  : 4'd0;
  assign w_dcp_ret[0]  = bus.rcv_xmt_tlx_credit_valid ? bus.rcv_xmt_tlx_credit_dcp0 : 6'd0;
  assign w_dcp_ret[1]  = bus.rcv_xmt_tlx_credit_valid ? bus.rcv_xmt_tlx_credit_dcp3 : 6'd0;
  assign w_vc_cons     = {bus.xmt_vc3_consume, bus.xmt_vc0_consume};
  assign w_dcp_cons[0] = bus.xmt_dcp0_consume;
  assign w_dcp_cons[1] = bus.xmt_dcp3_consume;

  // dcp1 has two sources; both in one cycle must count as two credits
  assign w_pvc_inc     = {bus.rcv_xmt_tl_credit_vc1_valid, bus.rcv_xmt_tl_credit_vc0_valid};
  assign w_pdcp_inc[0] = {1'b0, bus.rcv_xmt_tl_credit_dcp0_valid};
  assign w_pdcp_inc[1] = {1'b0, bus.rcv_xmt_tl_credit_dcp1_valid}
                       + {1'b0, bus.rcv_xmt_tl_crd_cfg_dcp1_valid};

  assign w_any   = (|w_pvc_cnt) || (|w_pdcp_cnt);
  assign w_start = (r_state == S_IDLE) && w_any;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    // Snapshot is capped to the request field width; the remainder stays pending
    assign w_snap_vc[g]  = (w_pvc_cnt[g]  > 7'd15) ? 4'hF  : w_pvc_cnt[g][3:0];
    assign w_snap_dcp[g] = (w_pdcp_cnt[g] > 8'd63) ? 6'h3F : w_pdcp_cnt[g][5:0];
    assign w_pvc_sub[g]  = w_start ? w_snap_vc[g]  : 4'd0;
    assign w_pdcp_sub[g] = w_start ? w_snap_dcp[g] : 6'd0;

    ocx_tlx_xmt_crd_cnt #(.W(VC_W), .ADD_W(4), .SUB_W(1)) u_tlx_vc (
      .tlx_clk(tlx_clk), .reset_n(reset_n), .i_clr(w_clr),
      .i_add(w_vc_ret[g]), .i_sub(w_vc_cons[g]),
      .o_cnt(w_vc_cnt[g]), .o_ovf(w_ovf[g]), .o_unf(w_unf[g]));

    ocx_tlx_xmt_crd_cnt #(.W(DCP_W), .ADD_W(6), .SUB_W(3)) u_tlx_dcp (
      .tlx_clk(tlx_clk), .reset_n(reset_n), .i_clr(w_clr),
      .i_add(w_dcp_ret[g]), .i_sub(w_dcp_cons[g]),
      .o_cnt(w_dcp_cnt[g]), .o_ovf(w_ovf[2+g]), .o_unf(w_unf[2+g]));

    ocx_tlx_xmt_crd_cnt #(.W(7), .ADD_W(1), .SUB_W(4)) u_pend_vc (
      .tlx_clk(tlx_clk), .reset_n(reset_n), .i_clr(w_clr),
      .i_add(w_pvc_inc[g]), .i_sub(w_pvc_sub[g]),
      .o_cnt(w_pvc_cnt[g]), .o_ovf(w_ovf[4+g]), .o_unf(w_unf[4+g]));

    ocx_tlx_xmt_crd_cnt #(.W(8), .ADD_W(2), .SUB_W(6)) u_pend_dcp (
      .tlx_clk(tlx_clk), .reset_n(reset_n), .i_clr(w_clr),
      .i_add(w_pdcp_inc[g]), .i_sub(w_pdcp_sub[g]),
      .o_cnt(w_pdcp_cnt[g]), .o_ovf(w_ovf[6+g]), .o_unf(w_unf[6+g]));
  end

  // Return FSM: snapshot pending credits into a request and hold it until taken
  always_ff @(posedge tlx_clk or negedge reset_n) begin
    if (!reset_n || !bus.dlx_tlx_link_up) begin
      r_state     <= S_IDLE;
      r_ret_valid <= 1'b0;
      r_ret_vc    <= '0;
      r_ret_dcp   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_any) begin
          r_state     <= S_HOLD;
          r_ret_valid <= 1'b1;
          r_ret_vc    <= w_snap_vc;
          r_ret_dcp   <= w_snap_dcp;
        end
        S_HOLD: if (bus.crd_ret_taken) begin
          r_state     <= S_IDLE;
          r_ret_valid <= 1'b0;
          r_ret_vc    <= '0;
          r_ret_dcp   <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Sticky error flags; only reset clears them, link-down merely stops new sets
  always_ff @(posedge tlx_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf_err <= 1'b0;
      r_unf_err <= 1'b0;
    end else if (bus.dlx_tlx_link_up) begin
      if (|w_ovf) r_ovf_err <= 1'b1;
      if (|w_unf) r_unf_err <= 1'b1;
    end
  end

  assign bus.tlx_vc0_credits   = w_vc_cnt[0];
  assign bus.tlx_vc3_credits   = w_vc_cnt[1];
  assign bus.tlx_dcp0_credits  = w_dcp_cnt[0];
  assign bus.tlx_dcp3_credits  = w_dcp_cnt[1];
  assign bus.crd_ret_valid     = r_ret_valid;
  assign bus.crd_ret_vc0       = r_ret_vc[0];
  assign bus.crd_ret_vc1       = r_ret_vc[1];
  assign bus.crd_ret_dcp0      = r_ret_dcp[0];
  assign bus.crd_ret_dcp1      = r_ret_dcp[1];
  assign bus.crd_overflow_err  = r_ovf_err;
  assign bus.crd_underflow_err = r_unf_err;
endmodule
